fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the 32-bit MIPS core. It owns the fetch PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions with their PC in a small prefetch queue. It presents them to the decode/execute datapath over a valid/ready interface. Branch and jump targets resolved downstream arrive as a redirect, which flushes the queue and restarts fetch.

## Interface
Parameters:
- DEPTH, 4, prefetch queue entries; power of 2, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word address of request; bits [1:0] always 0
- imem_ack  in  1  transfer completes in a cycle with imem_req && imem_ack
- imem_rdata  in  32  instruction word; valid when imem_ack is high
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch
- redirect_pc  in  32  new fetch address
- inst_valid  out  1  queue head valid
- inst_ready  in  1  consumer accepts head when inst_valid && inst_ready
- inst_data  out  32  head instruction
- inst_pc  out  32  PC of head instruction
- inst_pc_plus4  out  32  inst_pc + 4, modulo 2^32
- fetch_misalign  out  1  sticky misaligned-redirect flag; tied 0 unless FETCH_ALIGN_CHK_EN

## Operation
- The FSM has three states:
  - S_BOOT: reset state; imem_req=0; moves to S_RUN on the next edge.
  - S_RUN: imem_req = (count < DEPTH); moves to S_FULL when the queue becomes full.
  - S_FULL: imem_req=0; moves to S_RUN when a dequeue drops count below DEPTH.
- Any state goes to S_REDIR on redirect_valid. S_REDIR holds imem_req=0 for one bubble cycle, then moves to S_RUN.
- Only one request is outstanding at a time. imem_addr = fetch_pc and stays stable while imem_req is high without ack, except when a redirect aborts the request.
- On transfer (req && ack):
  - {fetch_pc, imem_rdata} is enqueued.
  - fetch_pc advances by 4, wrapping 32'hFFFF_FFFC → 0.
- Dequeue happens on inst_valid && inst_ready. Enqueue and dequeue in the same cycle leave count unchanged.
- Redirect has priority over everything in the same cycle:
  - The queue is emptied and count is cleared.
  - A concurrent ack's data is discarded.
  - A concurrent dequeue is ignored.
  - fetch_pc is loaded with {redirect_pc[31:2], 2'b00}.
- Queue read/write pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- Memory contract: an ack is meaningful only in a cycle where imem_req is high, and its data corresponds to the imem_addr of that cycle. Deasserting imem_req on redirect abandons the request; the memory must not ack it later.

## Timing
- Reset values (asynchronous):
  - imem_req=0, imem_addr=RESET_PC
  - inst_valid=0, inst_data=0, inst_pc=0, inst_pc_plus4=0
  - fetch_misalign=0, state=S_BOOT
- First request: imem_req=1 with imem_addr=RESET_PC in the second cycle after rst deasserts (the S_BOOT cycle comes first).
- Ack→valid latency: ack at cycle T gives inst_valid=1 at T+1. There is no bypass path.
- Redirect latency: redirect at cycle T puts the queue empty and inst_valid=0 at T+1 (S_REDIR). imem_req=1 with the new address follows at T+2.
- Full queue: imem_req drops in the cycle after count reaches DEPTH. It reasserts in the cycle after the first dequeue.
- Back-to-back: with ack tied high and inst_ready high, the unit sustains one instruction per cycle.
- rst asserted mid-transfer: everything clears immediately and any in-flight data is lost.

## Configuration
- FETCH_ALIGN_CHK_EN, when defined:
  - A redirect with redirect_pc[1:0]≠0 sets fetch_misalign, which is sticky.
  - The FSM stays in S_REDIR with imem_req=0 until a later aligned redirect clears the flag and resumes fetch.
- FETCH_ALIGN_CHK_EN, when not defined:
  - redirect_pc[1:0] is silently ignored.
  - fetch_misalign is constant 0.

## Structure
- Shared package mips_pkg holds:
  - ADDR_W=32 and INST_W=32
  - the fetch state enum {S_BOOT, S_RUN, S_FULL, S_REDIR}
  - NOP_INST=32'h0000_0000
- One sub-module, fetch_queue:
  - parameterised FIFO of {pc, inst} entries
  - push, pop and flush inputs; full and empty outputs; count output
- fetch_unit keeps the FSM, fetch_pc and the handshake logic.

## Test plan
- Reset then stream: RESET_PC=0x0, ack tied 1, ready=1 → addresses 0x0,0x4,0x8… on consecutive cycles; inst_pc lags imem_addr by 1 cycle; inst_pc_plus4 = inst_pc+4.
- Backpressure: DEPTH=4, ready=0, ack=1 → exactly 4 enqueues, then imem_req=0. Raise ready for 1 cycle → one dequeue, req reasserts next cycle, entry order preserved.
- Redirect with concurrent ack and dequeue: redirect_pc=0x100 while ack=1 and ready=1 → acked word dropped, inst_valid=0 next cycle, imem_addr=0x100 with req=1 two cycles after redirect.
- Slow memory: ack 3 cycles after req → imem_addr stable throughout; redirect during the wait aborts the request; no stale instruction appears at the output.
- PC wrap: redirect to 0xFFFF_FFFC → next fetch is 0x0000_0000; inst_pc_plus4 of the first instruction is 0x0.
- Macro on: redirect to 0x102 → fetch_misalign=1 and req stays 0. Redirect to 0x200 → flag clears and fetch resumes at 0x200. Macro off: the same stimulus fetches from 0x100.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
// Fetch FSM encoding and prefetch-queue entry layout live here.
package mips_pkg;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;

   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_FULL,
      S_REDIR
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(
      input logic [ADDR_W-1:0] a
   );
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, inst} entries with synchronous flush.
// Pointers wrap modulo DEPTH; count is one bit wider than the pointers.
module fetch_queue
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  fetch_entry_t             wdata_i,
   output fetch_entry_t             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   fetch_entry_t  mem_q [DEPTH];

   logic do_push;
   logic do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   // A push into a full queue is legal only when the head leaves the same cycle.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + 1'b1;
         if (do_pop)  rptr_d = rptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch: fetch PC, imem req/ack, prefetch queue, redirect.
// Define FETCH_ALIGN_CHK_EN to trap misaligned redirect targets.
module fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] inst_pc_plus4,
   output logic              fetch_misalign
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              misalign_hold;

   logic              push, pop;
   logic              q_full, q_empty;
   logic [CW-1:0]     q_count;
   fetch_entry_t      q_head;
   fetch_entry_t      q_wdata;

   assign q_wdata = '{pc: fetch_pc_q, inst: imem_rdata};

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .wdata_i (q_wdata),
      .rdata_o (q_head),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count)
   );

   // Redirect wins: an ack or dequeue in the redirect cycle is dropped.
   assign push = imem_req && imem_ack && !redirect_valid;
   assign pop  = inst_valid && inst_ready && !redirect_valid;

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      unique case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN: begin
            imem_req = !q_full;
            if (push && !pop && q_count == CW'(DEPTH - 1))
               state_d = S_FULL;
         end
         S_FULL:  if (pop) state_d = S_RUN;
         S_REDIR: state_d = misalign_hold ? S_REDIR : S_RUN;
         default: state_d = S_BOOT;
      endcase
      if (redirect_valid) state_d = S_REDIR;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid)
         fetch_pc_d = word_align(redirect_pc);
      else if (push)
         fetch_pc_d = fetch_pc_q + 32'd4;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_BOOT;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

`ifdef FETCH_ALIGN_CHK_EN
   logic misalign_q, misalign_d;

   always_comb begin
      misalign_d = misalign_q;
      if (redirect_valid) misalign_d = |redirect_pc[1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_d;
   end

   assign misalign_hold  = misalign_q;
   assign fetch_misalign = misalign_q;
`else
   assign misalign_hold  = 1'b0;
   assign fetch_misalign = 1'b0;
`endif

   assign imem_addr     = fetch_pc_q;
   assign inst_valid    = !q_empty;
   assign inst_data     = q_empty ? NOP_INST : q_head.inst;
   assign inst_pc       = q_empty ? '0 : q_head.pc;
   assign inst_pc_plus4 = q_empty ? '0 : q_head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit (DEPTH=4, RESET_PC=0).
// Honors FETCH_ALIGN_CHK_EN for the misaligned-redirect scenario.
module tb_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc_plus4;
   logic        fetch_misalign;

   int          vectors;
   int          miscompares;
   ent_t        sb[$];
   logic [31:0] exp_pc;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   assign imem_rdata = memf(imem_addr);

   fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_pc_plus4  (inst_pc_plus4),
      .fetch_misalign (fetch_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: push on transfer, pop and compare on dequeue.
   always @(negedge clk) begin
      ent_t e;
      if (rst) begin
         sb.delete();
         exp_pc = 32'h0;
      end else if (redirect_valid) begin
         sb.delete();
         exp_pc = {redirect_pc[31:2], 2'b00};
      end else begin
         if (inst_valid && inst_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL deq_unexpected: inst_pc=%h, none expected", inst_pc);
            end else begin
               e = sb.pop_front();
               if (inst_pc !== e.pc || inst_data !== e.inst ||
                   inst_pc_plus4 !== e.pc + 32'd4) begin
                  miscompares++;
                  $display("FAIL deq_entry: got pc=%h data=%h p4=%h want pc=%h data=%h p4=%h",
                           inst_pc, inst_data, inst_pc_plus4, e.pc, e.inst, e.pc + 32'd4);
               end
            end
         end
         if (imem_req && imem_ack) begin
            vectors++;
            if (imem_addr !== exp_pc) begin
               miscompares++;
               $display("FAIL xfer_addr: got %h want %h", imem_addr, exp_pc);
            end
            sb.push_back('{pc: exp_pc, inst: memf(exp_pc)});
            exp_pc = exp_pc + 32'd4;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      tick(); tick();
      vectors++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_ctrl: req=%b addr=%h valid=%b want 0/0/0", imem_req, imem_addr, inst_valid);
      end
      vectors++;
      if (inst_data !== 32'h0 || inst_pc !== 32'h0 || inst_pc_plus4 !== 32'h0 || fetch_misalign !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_data: data=%h pc=%h p4=%h mis=%b want 0", inst_data, inst_pc, inst_pc_plus4, fetch_misalign);
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL boot_req: got %b want 0", imem_req);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL first_req: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
      end
      tick();
   endtask

   task automatic test_stream();
      imem_ack = 1'b1; inst_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         vectors++;
         if (imem_req !== 1'b1 || imem_addr !== 32'(k * 4)) begin
            miscompares++;
            $display("FAIL stream_addr[%0d]: req=%b addr=%h want 1/%h", k, imem_req, imem_addr, 32'(k * 4));
         end
         if (k > 0) begin
            vectors++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'((k - 1) * 4)) begin
               miscompares++;
               $display("FAIL stream_lag[%0d]: valid=%b pc=%h want 1/%h", k, inst_valid, inst_pc, 32'((k - 1) * 4));
            end
         end
         tick();
      end
      imem_ack = 1'b0;
      tick();
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stream_drain: valid=%b want 0", inst_valid);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int n;
      n = 0;
      imem_ack = 1'b0; inst_ready = 1'b0;
      redirect(32'h40);
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_bubble: req=%b valid=%b want 0/0", imem_req, inst_valid);
      end
      tick();
      imem_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (imem_req && imem_ack) n++;
         tick();
      end
      @(negedge clk);
      vectors++;
      if (n != 4 || imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_full: enq=%0d req=%b want 4/0", n, imem_req);
      end
      tick();
      inst_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
         miscompares++;
         $display("FAIL bp_head: valid=%b pc=%h want 1/00000040", inst_valid, inst_pc);
      end
      tick();
      inst_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h50) begin
         miscompares++;
         $display("FAIL bp_rereq: req=%b addr=%h want 1/00000050", imem_req, imem_addr);
      end
      tick();
      imem_ack = 1'b0; inst_ready = 1'b1;
      repeat (5) tick();
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b0 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL bp_drain: valid=%b left=%0d want 0/0", inst_valid, sb.size());
      end
      tick();
   endtask

   task automatic test_redirect_concurrent();
      imem_ack = 1'b1; inst_ready = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || inst_valid !== 1'b1 || imem_addr !== 32'h60 || inst_pc !== 32'h5C) begin
         miscompares++;
         $display("FAIL rc_pre: req=%b valid=%b addr=%h pc=%h want 1/1/60/5c", imem_req, inst_valid, imem_addr, inst_pc);
      end
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL rc_flush: valid=%b req=%b want 0/0", inst_valid, imem_req);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         miscompares++;
         $display("FAIL rc_restart: req=%b addr=%h want 1/00000100", imem_req, imem_addr);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
         miscompares++;
         $display("FAIL rc_first: valid=%b pc=%h want 1/00000100", inst_valid, inst_pc);
      end
      tick();
      imem_ack = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_slow_memory();
      imem_ack = 1'b0; inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin
            miscompares++;
            $display("FAIL slow_hold[%0d]: req=%b addr=%h want 1/00000108", i, imem_req, imem_addr);
         end
         tick();
      end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h108) begin
         miscompares++;
         $display("FAIL slow_data: valid=%b pc=%h want 1/00000108", inst_valid, inst_pc);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin
         miscompares++;
         $display("FAIL slow_next: req=%b addr=%h want 1/0000010c", imem_req, imem_addr);
      end
      tick();
      redirect(32'h300);
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL slow_abort: valid=%b req=%b want 0/0", inst_valid, imem_req);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h300 || inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL slow_wait[%0d]: req=%b addr=%h valid=%b want 1/300/0", i, imem_req, imem_addr, inst_valid);
         end
         tick();
      end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h300) begin
         miscompares++;
         $display("FAIL slow_new: valid=%b pc=%h want 1/00000300", inst_valid, inst_pc);
      end
      tick();
      tick();
   endtask

   task automatic test_pc_wrap();
      imem_ack = 1'b1; inst_ready = 1'b1;
      redirect(32'hFFFF_FFFC);
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_bubble: req=%b valid=%b want 0/0", imem_req, inst_valid);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         miscompares++;
         $display("FAIL wrap_top: req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (imem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC || inst_pc_plus4 !== 32'h0) begin
         miscompares++;
         $display("FAIL wrap_zero: addr=%h pc=%h p4=%h want 0/fffffffc/0", imem_addr, inst_pc, inst_pc_plus4);
      end
      tick();
      imem_ack = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_misalign();
      imem_ack = 1'b0; inst_ready = 1'b1;
      redirect(32'h102);
`ifdef FETCH_ALIGN_CHK_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (fetch_misalign !== 1'b1 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_hold[%0d]: mis=%b req=%b want 1/0", i, fetch_misalign, imem_req);
         end
         tick();
      end
      redirect(32'h200);
      @(negedge clk);
      vectors++;
      if (fetch_misalign !== 1'b0 || imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL mis_clear: mis=%b req=%b want 0/0", fetch_misalign, imem_req);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         miscompares++;
         $display("FAIL mis_resume: req=%b addr=%h want 1/00000200", imem_req, imem_addr);
      end
      tick();
`else
      @(negedge clk);
      vectors++;
      if (fetch_misalign !== 1'b0 || imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL mis_off: mis=%b req=%b want 0/0", fetch_misalign, imem_req);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         miscompares++;
         $display("FAIL mis_off_addr: req=%b addr=%h want 1/00000100", imem_req, imem_addr);
      end
      tick();
`endif
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reset_midflight();
      imem_ack = 1'b1; inst_ready = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      vectors++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_rst: valid=%b req=%b addr=%h pc=%h want 0/0/0/0", inst_valid, imem_req, imem_addr, inst_pc);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_boot: req=%b valid=%b want 0/0", imem_req, inst_valid);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_restart: req=%b addr=%h want 1/0", imem_req, imem_addr);
      end
      tick();
      imem_ack = 1'b0; inst_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b0 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL mid_drain: valid=%b left=%0d want 0/0", inst_valid, sb.size());
      end
      tick();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      exp_pc = 32'h0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_concurrent();
      test_slow_memory();
      test_pc_wrap();
      test_misalign();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
